// File: rtl/iecdrv_rom_arb.sv
// iecdrv_rom_arb
// Time-division arbiter letting up to eight drive cores share one synchronous
// ROM. A ph2_f strobe snapshots every drive's address and enable. The
// snapshot is then issued to the ROM one slot per cycle in fixed drive order.
// Each returned word goes back to its drive with a one-cycle valid pulse.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   ph2_f               - single-cycle strobe starting (or restarting) a round
//   drv_en[DRIVES]      - per-drive enable, sampled with ph2_f
//   drv_addr            - flattened drive addresses, drive k at [k*AW +: AW]
//   drv_data            - flattened registered read data, drive k at [k*DW +: DW]
//   drv_valid[DRIVES]   - one-cycle pulse when drive k's data updates
//   rom_addr            - registered ROM address
//   rom_q               - ROM data, valid LAT cycles after rom_addr
//   busy                - high while a round is in flight
//   overrun, overrun_clr- sticky "ph2_f while busy" flag and its clear
module iecdrv_rom_arb #(
    parameter int DRIVES = 4,
    parameter int AW     = 15,
    parameter int DW     = 8,
    parameter int LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ph2_f,
    input  logic [DRIVES-1:0]    drv_en,
    input  logic [DRIVES*AW-1:0] drv_addr,
    output logic [DRIVES*DW-1:0] drv_data,
    output logic [DRIVES-1:0]    drv_valid,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_q,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int SW = $clog2(DRIVES + LAT + 2);
    localparam logic [SW-1:0] S_ONE = SW'(1);
    localparam logic [SW-1:0] S_DRV = SW'(DRIVES);
    localparam logic [SW-1:0] S_LAT = SW'(LAT);
    localparam logic [SW-1:0] S_END = SW'(DRIVES + LAT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          s_q, s_d;
    logic [DRIVES*AW-1:0]   snap_addr_q, snap_addr_d;
    logic [DRIVES-1:0]      snap_en_q, snap_en_d;
    logic [AW-1:0]          rom_addr_q, rom_addr_d;
    logic [DRIVES*DW-1:0]   data_q, data_d;
    logic [DRIVES-1:0]      valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    logic [SW-1:0]          issue_idx_s;
    logic [SW-1:0]          cap_idx_s;
    logic [AW-1:0]          issue_addr_s;
    logic                   capture_s;

    // Slot decode. Slot 0 is loaded on the ph2_f edge, so while s counts in
    // RUN the next address to issue belongs to slot s+1. The word for slot k
    // arrives on rom_q when s == k+LAT.
    always_comb begin
        issue_idx_s  = s_q + S_ONE;
        cap_idx_s    = s_q - S_LAT;
        issue_addr_s = {AW{1'b0}};
        for (int k = 0; k < DRIVES; k++) begin
            issue_addr_s = issue_addr_s |
                           ({AW{issue_idx_s == SW'(k)}} & snap_addr_q[k*AW +: AW]);
        end
        if ((state_q == ST_RUN) && (s_q >= S_LAT) && (cap_idx_s < S_DRV)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Next-state logic: round control, issue, capture and overrun flag.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        snap_addr_d = snap_addr_q;
        snap_en_d   = snap_en_q;
        rom_addr_d  = rom_addr_q;
        data_d      = data_q;
        valid_d     = {DRIVES{1'b0}};
        overrun_d   = overrun_q;

        if (ph2_f) begin
            // A strobe (re)starts the round. Any capture due this cycle is
            // dropped, so an abandoned round delivers nothing more.
            state_d     = ST_RUN;
            s_d         = {SW{1'b0}};
            snap_addr_d = drv_addr;
            snap_en_d   = drv_en;
            rom_addr_d  = drv_addr[AW-1:0];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    for (int k = 0; k < DRIVES; k++) begin
                        if (capture_s && (cap_idx_s == SW'(k)) && snap_en_q[k]) begin
                            data_d[k*DW +: DW] = rom_q;
                            valid_d[k]         = 1'b1;
                        end else begin
                            valid_d[k] = 1'b0;
                        end
                    end
                    if (issue_idx_s < S_DRV) begin
                        rom_addr_d = issue_addr_s;
                    end else begin
                        rom_addr_d = rom_addr_q;
                    end
                    if (s_q == S_END) begin
                        state_d = ST_IDLE;
                        s_d     = {SW{1'b0}};
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    s_d     = {SW{1'b0}};
                end
            endcase
        end

        // Setting the flag wins over a same-cycle clear.
        if (ph2_f && (state_q == ST_RUN)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= {SW{1'b0}};
            snap_addr_q <= {(DRIVES*AW){1'b0}};
            snap_en_q   <= {DRIVES{1'b0}};
            rom_addr_q  <= {AW{1'b0}};
            data_q      <= {(DRIVES*DW){1'b0}};
            valid_q     <= {DRIVES{1'b0}};
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            snap_addr_q <= snap_addr_d;
            snap_en_q   <= snap_en_d;
            rom_addr_q  <= rom_addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign drv_data  = data_q;
    assign drv_valid = valid_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = (state_q == ST_RUN);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_iecdrv_rom_arb.sv
module tb_iecdrv_rom_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] rom_f(input logic [14:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // ---------------- DUT A: DRIVES=4, LAT=1 ----------------
    logic        a_reset, a_ph2, a_clr;
    logic [3:0]  a_en, a_valid;
    logic [59:0] a_addr;
    logic [31:0] a_data;
    logic [14:0] a_rom;
    logic [7:0]  a_q;
    logic        a_busy, a_ovr;

    iecdrv_rom_arb #(.DRIVES(4), .AW(15), .DW(8), .LAT(1)) u_a (
        .clk(clk), .reset(a_reset), .ph2_f(a_ph2), .drv_en(a_en), .drv_addr(a_addr),
        .drv_data(a_data), .drv_valid(a_valid), .rom_addr(a_rom), .rom_q(a_q),
        .busy(a_busy), .overrun(a_ovr), .overrun_clr(a_clr));

    always @(posedge clk) a_q <= rom_f(a_rom);

    // ---------------- DUT B: DRIVES=8, LAT=3 ----------------
    logic         b_reset, b_ph2, b_clr;
    logic [7:0]   b_en, b_valid;
    logic [119:0] b_addr;
    logic [63:0]  b_data;
    logic [14:0]  b_rom;
    logic [7:0]   b_q, b_p1, b_p2;
    logic         b_busy, b_ovr;

    iecdrv_rom_arb #(.DRIVES(8), .AW(15), .DW(8), .LAT(3)) u_b (
        .clk(clk), .reset(b_reset), .ph2_f(b_ph2), .drv_en(b_en), .drv_addr(b_addr),
        .drv_data(b_data), .drv_valid(b_valid), .rom_addr(b_rom), .rom_q(b_q),
        .busy(b_busy), .overrun(b_ovr), .overrun_clr(b_clr));

    always @(posedge clk) begin
        b_p1 <= rom_f(b_rom);
        b_p2 <= b_p1;
        b_q  <= b_p2;
    end

    // ---------------- DUT C: DRIVES=1, LAT=3 ----------------
    logic        c_reset, c_ph2, c_clr;
    logic [0:0]  c_en, c_valid;
    logic [14:0] c_addr, c_rom;
    logic [7:0]  c_data, c_q, c_p1, c_p2;
    logic        c_busy, c_ovr;

    iecdrv_rom_arb #(.DRIVES(1), .AW(15), .DW(8), .LAT(3)) u_c (
        .clk(clk), .reset(c_reset), .ph2_f(c_ph2), .drv_en(c_en), .drv_addr(c_addr),
        .drv_data(c_data), .drv_valid(c_valid), .rom_addr(c_rom), .rom_q(c_q),
        .busy(c_busy), .overrun(c_ovr), .overrun_clr(c_clr));

    always @(posedge clk) begin
        c_p1 <= rom_f(c_rom);
        c_p2 <= c_p1;
        c_q  <= c_p2;
    end

    // ---------------- common helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for DUT A, expressed in round timing:
    // a round started by ph2_f in cycle t issues slot k in cycle t+1+k,
    // delivers it in cycle t+3+k and is busy over t+1..t+6.
    int          m_cyc;
    int          m_last;
    bit          m_have;
    logic [14:0] m_snap [4];
    logic [3:0]  m_en;
    logic [7:0]  m_data [4];
    logic        m_ovr;

    function automatic bit m_busy(input int c);
        return m_have && (c >= m_last + 1) && (c <= m_last + 6);
    endfunction

    function automatic logic [52:0] model_exp();
        logic        b;
        logic [14:0] r;
        logic [3:0]  v;
        int          d;
        int          k;
        b = m_busy(m_cyc);
        r = 15'h0;
        v = 4'h0;
        if (m_have) begin
            d = m_cyc - m_last - 1;
            if (d < 4) r = m_snap[d];
            else       r = m_snap[3];
            k = m_cyc - m_last - 3;
            if (k >= 0 && k < 4 && m_en[k]) v[k] = 1'b1;
        end
        return {b, r, v, m_data[3], m_data[2], m_data[1], m_data[0], m_ovr};
    endfunction

    task automatic model_update();
        int k;
        if (a_reset) begin
            m_have = 1'b0;
            m_ovr  = 1'b0;
            for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        end else begin
            if (a_ph2 && m_busy(m_cyc)) m_ovr = 1'b1;
            else if (a_clr)             m_ovr = 1'b0;
            if (a_ph2) begin
                m_have = 1'b1;
                m_last = m_cyc;
                m_en   = a_en;
                for (int i = 0; i < 4; i++) m_snap[i] = a_addr[i*15 +: 15];
            end
            if (m_have) begin
                k = m_cyc + 1 - m_last - 3;
                if (k >= 0 && k < 4 && m_en[k]) m_data[k] = rom_f(m_snap[k]);
            end
        end
    endtask

    task automatic step(input bit do_check);
        if (do_check)
            chk("model", 128'({a_busy, a_rom, a_valid, a_data, a_ovr}), 128'(model_exp()));
        model_update();
        tick();
        m_cyc++;
    endtask

    // Directed vector table for DUT A: one row per cycle, starting at a ph2_f.
    typedef struct {
        logic        ph2;
        logic        clr;
        logic [3:0]  en;
        logic [59:0] addr;
        logic        busy;
        logic [14:0] rom;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ph2, input logic clr, input logic [3:0] en,
                       input logic [59:0] addr, input logic busy, input logic [14:0] rom,
                       input logic [3:0] valid, input logic [31:0] data, input logic ovr);
        vec_t v;
        v.ph2 = ph2; v.clr = clr; v.en = en; v.addr = addr; v.busy = busy;
        v.rom = rom; v.valid = valid; v.data = data; v.ovr = ovr;
        vecs.push_back(v);
    endtask

    function automatic logic [59:0] pack4(input logic [14:0] a0, input logic [14:0] a1,
                                          input logic [14:0] a2, input logic [14:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        logic [59:0]  p1, px, p3, p4a, p4b;
        logic [63:0]  rnd;
        logic [63:0]  b_exp;
        logic [7:0]   b_ev;
        int           vcnt;

        a_reset = 1'b1; a_ph2 = 1'b0; a_clr = 1'b0; a_en = 4'hF; a_addr = 60'h0;
        b_reset = 1'b1; b_ph2 = 1'b0; b_clr = 1'b0; b_en = 8'hFF; b_addr = 120'h0;
        c_reset = 1'b1; c_ph2 = 1'b0; c_clr = 1'b0; c_en = 1'b1;  c_addr = 15'h0;
        m_cyc = 0; m_last = 0; m_have = 1'b0; m_ovr = 1'b0; m_en = 4'h0;
        for (int i = 0; i < 4; i++) begin m_data[i] = 8'h00; m_snap[i] = 15'h0; end

        p1  = pack4(15'h0010, 15'h0020, 15'h0030, 15'h0040);
        px  = pack4(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF);
        p3  = pack4(15'h0100, 15'h0111, 15'h0122, 15'h0133);
        p4a = pack4(15'h0001, 15'h0002, 15'h0003, 15'h0004);
        p4b = pack4(15'h0050, 15'h0060, 15'h0070, 15'h0080);

        // basic round
        add(1, 0, 4'hF, p1, 0, 15'h000, 4'h0, 32'h00000000, 0);
        add(0, 0, 4'hF, p1, 1, 15'h010, 4'h0, 32'h00000000, 0);
        add(0, 0, 4'hF, p1, 1, 15'h020, 4'h0, 32'h00000000, 0);
        add(0, 0, 4'hF, p1, 1, 15'h030, 4'h1, 32'h0000004A, 0);
        add(0, 0, 4'hF, p1, 1, 15'h040, 4'h2, 32'h00007A4A, 0);
        add(0, 0, 4'hF, p1, 1, 15'h040, 4'h4, 32'h006A7A4A, 0);
        add(0, 0, 4'hF, p1, 1, 15'h040, 4'h8, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, p1, 0, 15'h040, 4'h0, 32'h1A6A7A4A, 0);
        // addresses change after the snapshot
        add(1, 0, 4'hF, p1, 0, 15'h040, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 1, 15'h010, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 1, 15'h020, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 1, 15'h030, 4'h1, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 1, 15'h040, 4'h2, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 1, 15'h040, 4'h4, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 1, 15'h040, 4'h8, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hF, px, 0, 15'h040, 4'h0, 32'h1A6A7A4A, 0);
        // enable mask 1010
        add(1, 0, 4'hA, p3, 0, 15'h040, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hA, p3, 1, 15'h100, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hA, p3, 1, 15'h111, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hA, p3, 1, 15'h122, 4'h0, 32'h1A6A7A4A, 0);
        add(0, 0, 4'hA, p3, 1, 15'h133, 4'h2, 32'h1A6A4B4A, 0);
        add(0, 0, 4'hA, p3, 1, 15'h133, 4'h0, 32'h1A6A4B4A, 0);
        add(0, 0, 4'hA, p3, 1, 15'h133, 4'h8, 32'h696A4B4A, 0);
        add(0, 0, 4'hA, p3, 0, 15'h133, 4'h0, 32'h696A4B4A, 0);
        // restart while busy, with a same-cycle clear, then a lone clear
        add(1, 0, 4'hF, p4a, 0, 15'h133, 4'h0, 32'h696A4B4A, 0);
        add(0, 0, 4'hF, p4a, 1, 15'h001, 4'h0, 32'h696A4B4A, 0);
        add(0, 0, 4'hF, p4a, 1, 15'h002, 4'h0, 32'h696A4B4A, 0);
        add(1, 1, 4'hF, p4b, 1, 15'h003, 4'h1, 32'h696A4B5B, 0);
        add(0, 0, 4'hF, p4b, 1, 15'h050, 4'h0, 32'h696A4B5B, 1);
        add(0, 0, 4'hF, p4b, 1, 15'h060, 4'h0, 32'h696A4B5B, 1);
        add(0, 0, 4'hF, p4b, 1, 15'h070, 4'h1, 32'h696A4B0A, 1);
        add(0, 0, 4'hF, p4b, 1, 15'h080, 4'h2, 32'h696A3A0A, 1);
        add(0, 0, 4'hF, p4b, 1, 15'h080, 4'h4, 32'h692A3A0A, 1);
        add(0, 0, 4'hF, p4b, 1, 15'h080, 4'h8, 32'hDA2A3A0A, 1);
        add(0, 1, 4'hF, p4b, 0, 15'h080, 4'h0, 32'hDA2A3A0A, 1);
        add(0, 0, 4'hF, p4b, 0, 15'h080, 4'h0, 32'hDA2A3A0A, 0);

        // ---- DUT A: reset, directed table, then random traffic ----
        step(1'b0);
        step(1'b0);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        step(1'b1);
        step(1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            a_ph2 = vecs[i].ph2; a_clr = vecs[i].clr; a_en = vecs[i].en; a_addr = vecs[i].addr;
            chk($sformatf("vec%0d", i),
                128'({a_busy, a_rom, a_valid, a_data, a_ovr}),
                128'({vecs[i].busy, vecs[i].rom, vecs[i].valid, vecs[i].data, vecs[i].ovr}));
            step(1'b1);
        end

        for (int i = 0; i < 500; i++) begin
            rnd     = {$urandom(), $urandom()};
            a_addr  = rnd[59:0];
            a_en    = 4'($urandom_range(0, 15));
            a_ph2   = ($urandom_range(0, 5) == 0);
            a_clr   = ($urandom_range(0, 7) == 0);
            a_reset = ($urandom_range(0, 96) == 0);
            step(1'b1);
        end
        a_ph2 = 1'b0; a_clr = 1'b0; a_reset = 1'b0;

        // ---- DUT B: DRIVES=8, LAT=3 spacing and mid-round reset ----
        b_reset = 1'b1; tick(); tick(); b_reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b_addr[k*15 +: 15] = 15'(k * 16'h0111);
            b_exp[k*8 +: 8]    = 8'(k * 17) ^ 8'h5A;
        end
        tick();
        for (int i = 0; i < 13; i++) begin
            b_ph2 = (i == 0);
            b_ev  = (i >= 5 && i <= 12) ? 8'(1 << (i - 5)) : 8'h00;
            chk($sformatf("b_busy%0d", i), 128'(b_busy), 128'(i >= 1 && i <= 12));
            chk($sformatf("b_valid%0d", i), 128'(b_valid), 128'(b_ev));
            if (i >= 1 && i <= 8)
                chk($sformatf("b_rom%0d", i), 128'(b_rom), 128'(15'((i - 1) * 16'h0111)));
            tick();
        end
        chk("b_data", 128'(b_data), 128'(b_exp));
        b_ph2 = 1'b1;
        tick();
        b_ph2 = 1'b0;
        chk("b_sp13_ovr", 128'(b_ovr), 128'(0));
        chk("b_sp13_busy", 128'(b_busy), 128'(1));
        repeat (11) tick();
        b_ph2 = 1'b1;
        tick();
        b_ph2 = 1'b0;
        chk("b_sp12_ovr", 128'(b_ovr), 128'(1));
        chk("b_sp12_rom", 128'(b_rom), 128'(15'h0000));
        tick(); tick();
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        chk("b_rst_outs", 128'({b_busy, b_rom, b_valid, b_data, b_ovr}), 128'(0));
        vcnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (b_valid != 8'h00) vcnt++;
            tick();
        end
        chk("b_rst_novalid", 128'(vcnt), 128'(0));

        // ---- DUT C: DRIVES=1, LAT=3 ----
        c_reset = 1'b1; tick(); tick(); c_reset = 1'b0;
        c_addr = 15'h1234;
        tick();
        for (int i = 0; i < 7; i++) begin
            c_ph2 = (i == 0);
            chk($sformatf("c_busy%0d", i), 128'(c_busy), 128'(i >= 1 && i <= 5));
            chk($sformatf("c_valid%0d", i), 128'(c_valid), 128'(i == 5));
            if (i >= 1) chk($sformatf("c_rom%0d", i), 128'(c_rom), 128'(15'h1234));
            if (i >= 5) chk($sformatf("c_data%0d", i), 128'(c_data), 128'(8'h6E));
            tick();
        end
        c_ph2 = 1'b1;
        tick();
        c_ph2 = 1'b0;
        chk("c_sp7_ovr", 128'(c_ovr), 128'(0));
        chk("c_sp7_busy", 128'(c_busy), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
